// File: rtl/rr_arbiter_8_pkg.sv
// Purpose: shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ / IDX_W : requester count and grant index width
//   state_e         : arbiter FSM state encodings
//   rr_select()     : rotate-priority pick of the next grantee after ptr
package rr_arbiter_8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned IDX_W1  = IDX_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Rotate req so bit 0 is requester ptr+1, take the lowest set bit,
  // then add the rotation back (mod NUM_REQ). Returns ptr+1 when req is 0;
  // callers only use the result when some request is present.
  function automatic logic [IDX_W-1:0] rr_select(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [IDX_W1-1:0]    start;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     ofs;
    dbl   = {req, req};
    start = {1'b0, ptr} + IDX_W1'(1);
    rot   = dbl[start +: NUM_REQ];
    ofs   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) ofs = IDX_W'(i);
    end
    return IDX_W'(start + {1'b0, ofs});
  endfunction

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// Purpose: gate-level 3-to-8 one-hot decoder.
//   a : 3-bit binary index in
//   y : one-hot output, y[a] = 1
module rr_arbiter_8_decoder
  import rr_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0]   a,
  output logic [NUM_REQ-1:0] y
);

  logic [IDX_W-1:0] a_n;

  assign a_n  = ~a;

  assign y[0] = a_n[2] & a_n[1] & a_n[0];
  assign y[1] = a_n[2] & a_n[1] & a[0];
  assign y[2] = a_n[2] & a[1]   & a_n[0];
  assign y[3] = a_n[2] & a[1]   & a[0];
  assign y[4] = a[2]   & a_n[1] & a_n[0];
  assign y[5] = a[2]   & a_n[1] & a[0];
  assign y[6] = a[2]   & a[1]   & a_n[0];
  assign y[7] = a[2]   & a[1]   & a[0];

endmodule

// File: rtl/rr_arbiter_8.sv
// Purpose: round-robin arbiter for 8 requesters with optional hold limit.
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   en        : allows new grants; never revokes an active grant
//   req[7:0]  : level requests, held until serviced
//   gnt[7:0]  : one-hot grant, zero when no grant is active
//   gnt_idx   : index of the current/last grantee
//   gnt_valid : grant active
//   timeout   : one-cycle pulse when a grant is revoked by MAX_HOLD
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   sel;
  logic               req_any;
  logic               owner_req;
  logic               hold_limit;
  logic [NUM_REQ-1:0] dec_y;

  assign sel        = rr_select(req, ptr_q);
  assign req_any    = |req;
  assign owner_req  = req[gnt_idx_q];
  assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q  <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && req_any) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (!owner_req || hold_limit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered output / datapath next values
  always_comb begin
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && req_any) begin
          gnt_idx_d   = sel;
          gnt_valid_d = 1'b1;
          ptr_d       = sel;
          hold_cnt_d  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          gnt_valid_d = 1'b0;
        end else if (hold_limit) begin
          // ptr already equals the revoked grantee, so it drops to lowest priority
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  rr_arbiter_8_decoder u_dec (
    .a (gnt_idx_q),
    .y (dec_y)
  );

  // gnt is a pure function of flops, so it stays glitch-free
  assign gnt       = dec_y & {NUM_REQ{gnt_valid_q}};
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  localparam int unsigned MAX_HOLD   = 4;
  localparam int unsigned CNT_W      = 3;
  // Waiting cycles counted while en=1 or a grant is running: up to 7 other
  // grants of (issue cycle + MAX_HOLD), plus the cycle that issues our grant.
  localparam int unsigned STARVE_MAX = 7 * (MAX_HOLD + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] e8;
  logic [7:0] req_prev;
  int         wait_cnt [8];
  int         worst;

  always #5 clk = ~clk;

  rr_arbiter_8 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt",       32'(gnt),       32'h00);
    chk("rst_gnt_idx",   32'(gnt_idx),   32'd0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_timeout",   32'(timeout),   32'd0);

    // 1: single requester, 1-cycle grant latency
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'h01;
    tick();
    chk("t1_gnt",       32'(gnt),       32'h01);
    chk("t1_gnt_idx",   32'(gnt_idx),   32'd0);
    chk("t1_gnt_valid", 32'(gnt_valid), 32'd1);
    req = 8'h00;
    tick();
    chk("t1_rel_gnt",   32'(gnt),       32'h00);
    chk("t1_rel_valid", 32'(gnt_valid), 32'd0);
    chk("t1_rel_idx",   32'(gnt_idx),   32'd0);

    // 2: all requesting, hold limit rotates 0..7,0 with a timeout gap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      e8 = 8'(1 << (g % 8));
      for (int c = 0; c < int'(MAX_HOLD); c++) begin
        tick();
        chk("t2_gnt",     32'(gnt),     32'(e8));
        chk("t2_no_to",   32'(timeout), 32'd0);
      end
      tick();
      chk("t2_gap_gnt",   32'(gnt),       32'h00);
      chk("t2_gap_valid", 32'(gnt_valid), 32'd0);
      chk("t2_timeout",   32'(timeout),   32'd1);
    end
    req = 8'h00;
    tick();
    chk("t2_end_to", 32'(timeout), 32'd0);

    // 3: release of grant 3 with 5 and 1 pending -> gap then 5
    req = 8'h08;
    tick();
    chk("t3_gnt3", 32'(gnt), 32'h08);
    req = 8'h22;
    tick();
    chk("t3_gap_gnt", 32'(gnt),     32'h00);
    chk("t3_gap_to",  32'(timeout), 32'd0);
    tick();
    chk("t3_gnt5",     32'(gnt),     32'h20);
    chk("t3_gnt5_idx", 32'(gnt_idx), 32'd5);
    req = 8'h00;
    tick();

    // 4: en gates new grants only
    en  = 1'b0;
    req = 8'h10;
    tick();
    chk("t4_blocked_a", 32'(gnt), 32'h00);
    tick();
    chk("t4_blocked_b", 32'(gnt), 32'h00);
    en = 1'b1;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h10);
    en = 1'b0;
    tick();
    chk("t4_held_a", 32'(gnt), 32'h10);
    tick();
    chk("t4_held_b", 32'(gnt), 32'h10);
    req = 8'h00;
    tick();
    chk("t4_rel", 32'(gnt), 32'h00);

    // 5: reset mid-grant, then ptr restarts at 7
    en  = 1'b1;
    req = 8'h40;
    tick();
    chk("t5_gnt6", 32'(gnt), 32'h40);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_gnt",   32'(gnt),       32'h00);
    chk("t5_rst_valid", 32'(gnt_valid), 32'd0);
    chk("t5_rst_idx",   32'(gnt_idx),   32'd0);
    rst_n = 1'b1;
    req   = 8'h41;
    tick();
    chk("t5_gnt0",     32'(gnt),     32'h01);
    chk("t5_gnt0_idx", 32'(gnt_idx), 32'd0);
    req = 8'h00;
    tick();

    // Lone requester revoked by the limit is regranted after one idle cycle
    req = 8'h04;
    tick();
    chk("lone_gnt", 32'(gnt), 32'h04);
    for (int c = 1; c < int'(MAX_HOLD); c++) tick();
    chk("lone_last", 32'(gnt), 32'h04);
    tick();
    chk("lone_gap", 32'(gnt),     32'h00);
    chk("lone_to",  32'(timeout), 32'd1);
    tick();
    chk("lone_regnt",    32'(gnt),     32'h04);
    chk("lone_regnt_to", 32'(timeout), 32'd0);
    req = 8'h00;
    tick();
    chk("lone_rel", 32'(gnt), 32'h00);

    // 6: random requesters holding req until granted, random en
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (gnt[i] && ($urandom_range(0, 2) == 0)) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      en = ($urandom_range(0, 9) != 0);
      worst = 0;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !gnt[i]) begin
          if (en || gnt_valid) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      req_prev = req;
      tick();
      chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rnd_valid",  32'(gnt != 8'h00),  32'(gnt_valid));
      chk("rnd_nonreq", 32'(gnt & ~req_prev), 32'h00);
      chk("rnd_starve", 32'(worst > int'(STARVE_MAX)), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
